// File: rtl/rd_burst_ctrl_if.sv
// rd_burst_ctrl_if: Avalon-MM burst read bus plus capture FIFO write port.
interface rd_burst_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BCNT_W = 4,
  parameter int FREE_W = 10
);
  logic [ADDR_W-1:0] address;
  logic [BCNT_W-1:0] burstcount;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic [FREE_W-1:0] fifo_free;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_data;
  modport master (
    output address, burstcount, read, fifo_wr, fifo_data,
    input  waitrequest, readdata, readdatavalid, fifo_free
  );
  modport slave (
    input  address, burstcount, read, fifo_wr, fifo_data,
    output waitrequest, readdata, readdatavalid, fifo_free
  );
endinterface

// File: rtl/rd_burst_ctrl.sv
// rd_burst_ctrl: credit-gated Avalon-MM burst read master copying a packet into the capture FIFO.
module rd_burst_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int BCNT_W    = 4,
  parameter int FREE_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pkt_begin,
  input  logic [ADDR_W-1:0] pkt_end,
  output logic              busy,
  output logic              done,
  output logic              err,
  rd_burst_ctrl_if.master   bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int LW    = ADDR_W + 1;
  localparam int OW    = FREE_W + 1;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DRAIN, DONE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] beg_q, end_q, cur;
  logic [LW-1:0]     words_left, len_q, to_bnd, len;
  logic [OW-1:0]     outstanding;
  logic              err_q, bad, credit, acc, beat;
  assign bad    = end_q < beg_q || |(beg_q & ADDR_W'(BYTES-1)) || |(end_q & ADDR_W'(BYTES-1));
  assign to_bnd = LW'(MAX_BURST) - (LW'(cur >> BSH) & LW'(MAX_BURST-1));
  assign len    = words_left < to_bnd ? words_left : to_bnd;
  assign credit = (LW+1)'(bus.fifo_free) >= (LW+1)'(outstanding) + (LW+1)'(len);
  assign acc    = state == WAIT && !bus.waitrequest;
  assign beat   = bus.readdatavalid && outstanding != '0;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign err    = done && err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? CHECK : IDLE;
      CHECK:   state_n = bad ? DONE : ISSUE;
      ISSUE:   state_n = credit ? WAIT : ISSUE;
      WAIT:    state_n = !acc ? WAIT : words_left == len_q ? DRAIN : ISSUE;
      DRAIN:   state_n = outstanding == '0 ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beg_q          <= '0;
      end_q          <= '0;
      cur            <= '0;
      words_left     <= '0;
      len_q          <= '0;
      outstanding    <= '0;
      err_q          <= 1'b0;
      bus.read       <= 1'b0;
      bus.address    <= '0;
      bus.burstcount <= '0;
      bus.fifo_wr    <= 1'b0;
      bus.fifo_data  <= '0;
    end else begin
      if (state == IDLE && start) begin
        beg_q <= pkt_begin;
        end_q <= pkt_end;
        err_q <= 1'b0;
      end
      if (state == CHECK) begin
        err_q      <= bad;
        words_left <= LW'((end_q - beg_q) >> BSH) + LW'(1);
        cur        <= beg_q;
      end
      if (state == ISSUE && credit) begin
        bus.read       <= 1'b1;
        bus.address    <= cur;
        bus.burstcount <= BCNT_W'(len);
        len_q          <= len;
      end
      if (acc) begin
        bus.read   <= 1'b0;
        cur        <= cur + ADDR_W'(len_q << BSH);
        words_left <= words_left - len_q;
      end
      outstanding <= outstanding + (acc ? OW'(len_q) : OW'(0)) - (beat ? OW'(1) : OW'(0));
      bus.fifo_wr <= beat;
      if (beat) bus.fifo_data <= bus.readdata;
    end
  end
endmodule
